// File: rtl/store_commit_buffer_if.sv
// Store queue bus bundle: the LSU push channel (st_*) and the D$ drain channel (mem_*).
//   slave  : the store commit buffer. It accepts pushes, drives mem_req/addr/data/be and takes mem_gnt.
//   master : the environment (LSU + D$). It drives pushes and mem_gnt.
interface store_commit_buffer_if #(
  parameter int PLEN = 56,
  parameter int XLEN = 64
);
  logic              st_valid_i;
  logic              st_ready_o;
  logic [PLEN-1:0]   st_paddr_i;
  logic [XLEN-1:0]   st_data_i;
  logic [XLEN/8-1:0] st_be_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [PLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_data_o;
  logic [XLEN/8-1:0] mem_be_o;

  modport slave (
    input  st_valid_i, st_paddr_i, st_data_i, st_be_i, mem_gnt_i,
    output st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o
  );
  modport master (
    output st_valid_i, st_paddr_i, st_data_i, st_be_i, mem_gnt_i,
    input  st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Circular store queue behind the commit stage.
// Stores are pushed speculatively by the LSU. Each commit_i pulse commits the oldest
// speculative store. Committed stores drain in order to the D$ via the req/gnt handshake.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                discard all uncommitted stores (after this cycle's commit)
//   bus (slave)            st_* push channel, mem_* drain channel
//   commit_i               commit oldest speculative store
//   commit_ready_o         a speculative store exists
//   no_st_pending_o        queue completely empty
//   page_offset_i          load offset to check against queued stores
//   page_offset_match_o    some occupied entry has paddr[11:3] == page_offset_i[11:3]
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  store_commit_buffer_if.slave bus,
  input  logic                 commit_i,
  output logic                 commit_ready_o,
  output logic                 no_st_pending_o,
  input  logic [11:0]          page_offset_i,
  output logic                 page_offset_match_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // counters span 0..DEPTH

  typedef struct packed {
    logic [PLEN-1:0]   paddr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr, cm_ptr, wr_ptr, cm_nxt;
  logic [CW-1:0]   com_cnt, spec_cnt, total;
  logic            push, commit, grant;

  assign total           = com_cnt + spec_cnt;
  assign bus.st_ready_o  = (total < CW'(DEPTH));
  assign commit_ready_o  = (spec_cnt != '0);
  assign no_st_pending_o = (total == '0);
  assign bus.mem_req_o   = (com_cnt != '0);
  assign bus.mem_addr_o  = mem_q[rd_ptr].paddr;
  assign bus.mem_data_o  = mem_q[rd_ptr].data;
  assign bus.mem_be_o    = mem_q[rd_ptr].be;

  assign push   = bus.st_valid_i && bus.st_ready_o && !flush_i;
  assign commit = commit_i && commit_ready_o;
  assign grant  = bus.mem_req_o && bus.mem_gnt_i;
  // Flush rewinds wr_ptr to the cm_ptr value that already includes this cycle's commit.
  assign cm_nxt = cm_ptr + AW'(commit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      wr_ptr   <= '0;
      com_cnt  <= '0;
      spec_cnt <= '0;
    end else begin
      rd_ptr  <= rd_ptr + AW'(grant);
      cm_ptr  <= cm_nxt;
      com_cnt <= com_cnt + CW'(commit) - CW'(grant);
      if (flush_i) begin
        wr_ptr   <= cm_nxt;
        spec_cnt <= '0;
      end else begin
        wr_ptr   <= wr_ptr + AW'(push);
        spec_cnt <= spec_cnt + CW'(push) - CW'(commit);
      end
    end
  end

  // Entry payload needs no reset; occupancy is tracked purely by the counters.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= '{paddr: bus.st_paddr_i, data: bus.st_data_i, be: bus.st_be_i};
  end

  // An entry is occupied when its distance from rd_ptr (mod DEPTH) is below total.
  logic [AW-1:0] offs;
  always_comb begin
    page_offset_match_o = 1'b0;
    offs                = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr;
      if ({1'b0, offs} < total && mem_q[i].paddr[11:3] == page_offset_i[11:3])
        page_offset_match_o = 1'b1;
    end
  end

  // Double-word granularity: the low offset bits take no part in the hazard check.
  logic unused_offs_lo;
  assign unused_offs_lo = ^page_offset_i[2:0];
endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;
  localparam int PLEN = 56;
  localparam int XLEN = 64;

  logic        clk = 0;
  logic        rst, flush, commit;
  logic        commit_ready, no_pend, match;
  logic [11:0] page_offset;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [PLEN-1:0] a;
    logic [XLEN-1:0] d;
    logic [7:0]      be;
  } st_t;
  st_t q[$];

  store_commit_buffer_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

  store_commit_buffer #(.DEPTH(8), .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .bus                 (bus.slave),
    .commit_i            (commit),
    .commit_ready_o      (commit_ready),
    .no_st_pending_o     (no_pend),
    .page_offset_i       (page_offset),
    .page_offset_match_o (match)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One push cycle; the model queue records it only when it is meant to be accepted.
  task automatic push(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                      input logic [7:0] be, input bit accepted);
    bus.st_valid_i = 1; bus.st_paddr_i = a; bus.st_data_i = d; bus.st_be_i = be;
    tick();
    bus.st_valid_i = 0;
    if (accepted) q.push_back('{a: a, d: d, be: be});
  endtask

  task automatic commit_n(input int n);
    commit = 1;
    repeat (n) tick();
    commit = 0;
  endtask

  // Check the head against the model, then grant it.
  task automatic drain_one(input string tag);
    st_t e;
    e = q.pop_front();
    chk({tag, "_req"},  64'(bus.mem_req_o),  64'd1);
    chk({tag, "_addr"}, 64'(bus.mem_addr_o), 64'(e.a));
    chk({tag, "_data"}, bus.mem_data_o,      e.d);
    chk({tag, "_be"},   64'(bus.mem_be_o),   64'(e.be));
    bus.mem_gnt_i = 1;
    tick();
    bus.mem_gnt_i = 0;
  endtask

  initial begin
    rst = 1; flush = 0; commit = 0; page_offset = 12'h000;
    bus.st_valid_i = 0; bus.st_paddr_i = '0; bus.st_data_i = '0; bus.st_be_i = '0;
    bus.mem_gnt_i = 0;
    tick(); tick();
    rst = 0;
    tick();

    // Reset / idle
    chk("rst_st_ready", 64'(bus.st_ready_o), 64'd1);
    chk("rst_commit_ready", 64'(commit_ready), 64'd0);
    chk("rst_no_pend", 64'(no_pend), 64'd1);
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst_match", 64'(match), 64'd0);

    // Single store round trip
    push(56'h1000, 64'h11, 8'hFF, 1);
    chk("a_commit_ready", 64'(commit_ready), 64'd1);
    chk("a_no_pend", 64'(no_pend), 64'd0);
    chk("a_req_before_commit", 64'(bus.mem_req_o), 64'd0);
    commit_n(1);
    chk("a_commit_ready_after", 64'(commit_ready), 64'd0);
    drain_one("a");
    chk("a_no_pend_after", 64'(no_pend), 64'd1);
    chk("a_req_after", 64'(bus.mem_req_o), 64'd0);

    // Fill to full, ignored 9th push, partial drain, wrap
    for (int i = 0; i < 8; i++) begin
      chk("fill_st_ready", 64'(bus.st_ready_o), 64'd1);
      push(56'h100 + 56'(i * 8), 64'hA0 + 64'(i), 8'(8'h01 << i), 1);
    end
    chk("full_st_ready", 64'(bus.st_ready_o), 64'd0);
    push(56'hDEAD0, 64'hBAD, 8'hFF, 0);
    chk("full_st_ready_9th", 64'(bus.st_ready_o), 64'd0);
    commit_n(3);
    chk("full_st_ready_commit", 64'(bus.st_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) drain_one("wrap_d1");
    chk("wrap_st_ready", 64'(bus.st_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) push(56'h300 + 56'(i * 8), 64'hC0 + 64'(i), 8'hF0, 1);
    commit_n(8);
    chk("wrap_commit_ready", 64'(commit_ready), 64'd0);
    while (q.size() != 0) drain_one("wrap_d2");
    chk("wrap_empty", 64'(no_pend), 64'd1);

    // Flush with concurrent commit and push: two committed, three speculative
    for (int i = 0; i < 5; i++) push(56'h500 + 56'(i * 8), 64'hB0 + 64'(i), 8'h0F, i < 3);
    commit_n(2);
    flush = 1; commit = 1;
    push(56'h5F0, 64'hEE, 8'hFF, 0);
    flush = 0; commit = 0;
    chk("flush_commit_ready", 64'(commit_ready), 64'd0);
    chk("flush_st_ready", 64'(bus.st_ready_o), 64'd1);
    commit_n(1);  // nothing speculative: ignored
    for (int i = 0; i < 3; i++) drain_one("flush_d");
    chk("flush_req_done", 64'(bus.mem_req_o), 64'd0);
    chk("flush_empty", 64'(no_pend), 64'd1);
    // wr_ptr must have been rewound so this lands in the slot rd_ptr reaches next
    push(56'h600, 64'hCC, 8'h3C, 1);
    commit_n(1);
    drain_one("flush_c");
    chk("flush_c_empty", 64'(no_pend), 64'd1);

    // Stall: head stays stable with no grant
    push(56'h700, 64'hD0, 8'h81, 1);
    commit_n(1);
    repeat (5) begin
      tick();
      chk("stall_req", 64'(bus.mem_req_o), 64'd1);
      chk("stall_addr", 64'(bus.mem_addr_o), 64'h700);
      chk("stall_data", bus.mem_data_o, 64'hD0);
      chk("stall_be", 64'(bus.mem_be_o), 64'h81);
    end

    // Simultaneous push, commit and grant
    push(56'h708, 64'hD1, 8'h42, 1);  // spec=1, com=1
    begin
      st_t e;
      e = q.pop_front();
      chk("sim_head_addr", 64'(bus.mem_addr_o), 64'(e.a));
    end
    bus.mem_gnt_i = 1; commit = 1;
    push(56'h710, 64'hD2, 8'h24, 1);
    bus.mem_gnt_i = 0; commit = 0;
    chk("sim_commit_ready", 64'(commit_ready), 64'd1);
    chk("sim_req", 64'(bus.mem_req_o), 64'd1);
    drain_one("sim_d1");
    chk("sim_req_gap", 64'(bus.mem_req_o), 64'd0);
    commit_n(1);
    drain_one("sim_d2");
    chk("sim_empty", 64'(no_pend), 64'd1);

    // Page offset hazard
    push(56'h2A48, 64'h77, 8'hFF, 1);
    page_offset = 12'hA4C; #1;
    chk("po_match", 64'(match), 64'd1);
    page_offset = 12'hA50; #1;
    chk("po_nomatch", 64'(match), 64'd0);
    page_offset = 12'hA4C;
    commit_n(1);
    chk("po_match_committed", 64'(match), 64'd1);
    drain_one("po_d");
    chk("po_match_drained", 64'(match), 64'd0);

    // Reset mid-drain drops committed entries
    push(56'h800, 64'h88, 8'hFF, 1);
    push(56'h808, 64'h89, 8'hFF, 1);
    commit_n(2);
    bus.mem_gnt_i = 1;
    tick();
    bus.mem_gnt_i = 0;
    rst = 1;
    tick();
    rst = 0;
    q.delete();
    chk("mrst_req", 64'(bus.mem_req_o), 64'd0);
    chk("mrst_no_pend", 64'(no_pend), 64'd1);
    chk("mrst_st_ready", 64'(bus.st_ready_o), 64'd1);
    tick();
    chk("mrst_req_later", 64'(bus.mem_req_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Circular store queue directly downstream of the commit stage.
- The LSU pushes translated stores speculatively. The commit stage's commit_lsu pulse marks the oldest speculative store as committed. Committed stores drain in order to the data cache through a req/gnt handshake.
- Provides the commit stage's commit_lsu_ready and no_st_pending inputs, and a page-offset hazard flag for the load unit.

Parameters:
- DEPTH, 8, total entries; power of two, >=2
- PLEN, 56, physical address width
- XLEN, 64, store data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  pipeline flush; discard all uncommitted stores
- st_valid_i  in  1  LSU store push valid
- st_ready_o  out  1  space available for a push
- st_paddr_i  in  PLEN  store physical address
- st_data_i  in  XLEN  store data, lane aligned
- st_be_i  in  XLEN/8  byte enables
- commit_i  in  1  commit oldest speculative store (commit_lsu_o of the commit stage)
- commit_ready_o  out  1  a speculative store exists to commit (to commit_lsu_ready_i)
- no_st_pending_o  out  1  queue completely empty (to no_st_pending_i)
- page_offset_i  in  12  load page offset for hazard check
- page_offset_match_o  out  1  a queued store overlaps that offset
- mem_req_o  out  1  drain request to D$
- mem_gnt_i  in  1  D$ accepts the head store
- mem_addr_o  out  PLEN  head committed store address
- mem_data_o  out  XLEN  head committed store data
- mem_be_o  out  XLEN/8  head committed store byte enables

Behaviour:
- Storage: DEPTH entries {paddr, data, be}.
- Three pointers of width clog2(DEPTH), all wrapping modulo DEPTH:
  - rd_ptr: oldest committed entry.
  - cm_ptr: oldest speculative entry.
  - wr_ptr: next free entry.
- Counters:
  - com_cnt: committed entries, 0..DEPTH.
  - spec_cnt: speculative entries, 0..DEPTH.
  - total = com_cnt + spec_cnt; the block never lets total exceed DEPTH.
- Reset (rst_i high at a clock edge): all pointers and counters go to 0; entry contents are don't-care.
  - Outputs after reset: st_ready_o=1, commit_ready_o=0, no_st_pending_o=1, mem_req_o=0, page_offset_match_o=0.
  - Reset asserted mid-drain drops all entries, including granted-pending ones; no further mem_req_o.
- All outputs are combinational from registered state plus page_offset_i. No input-to-output paths except page_offset_i -> page_offset_match_o.
- Push: accepted when st_valid_i && st_ready_o && !flush_i, with st_ready_o = (total < DEPTH).
  - Write the entry at wr_ptr, then wr_ptr++ and spec_cnt++.
  - A pushed store becomes committable the next cycle.
- Commit: effective when commit_i && spec_cnt != 0, with commit_ready_o = (spec_cnt != 0).
  - cm_ptr++, spec_cnt--, com_cnt++.
  - commit_i while spec_cnt == 0 is ignored and causes no state change.
- Drain:
  - mem_req_o = (com_cnt != 0).
  - mem_addr_o, mem_data_o and mem_be_o show the rd_ptr entry and stay stable until granted.
  - On mem_req_o && mem_gnt_i: rd_ptr++, com_cnt--. One grant per cycle; back-to-back grants drain one entry per cycle.
  - mem_gnt_i without mem_req_o is ignored.
- Flush:
  - Ordering within the cycle: commit is applied first. Then every remaining speculative entry is discarded: wr_ptr <= updated cm_ptr, spec_cnt <= 0.
  - A push in the same cycle as flush is dropped.
  - Committed entries are never discarded and continue draining during and after the flush.
- Simultaneous push, commit and grant in one cycle: all three take effect.
  - Counters update by net delta: spec_cnt +push -commit; com_cnt +commit -grant.
- Full: st_ready_o depends only on registered total, so a grant in the same cycle does not open space until the next cycle.
- no_st_pending_o = (total == 0).
- page_offset_match_o = 1 if any occupied entry (committed or speculative) has paddr[11:3] == page_offset_i[11:3].
- Pointer wrap: DEPTH-1 -> 0. Full and empty are distinguished by the counters, never by pointer equality.

Test Plan:
- Reset, then idle: st_ready_o=1, commit_ready_o=0, no_st_pending_o=1, mem_req_o=0.
- Push A (paddr 0x1000, data 0x11, be 0xFF) -> commit_ready_o=1 next cycle. Then pulse commit_i -> mem_req_o=1 with mem_addr_o=0x1000. Grant -> no_st_pending_o=1 next cycle.
- Push 8 stores with no commits -> st_ready_o=0 after the 8th and a 9th push is ignored. Commit 3, grant 3, push 3 more -> pointers wrap and the drain order equals the push order.
- Two committed and three speculative entries, assert flush_i together with commit_i and a push -> 3 committed entries remain, spec_cnt=0, the pushed store is absent, and draining continues for exactly 3 grants.
- Hold mem_gnt_i=0 for 5 cycles with a committed head -> mem_req_o, mem_addr_o, mem_data_o and mem_be_o stay constant. Same-cycle push, commit and grant -> counters net correctly and no entry is lost.
- Store queued at paddr 0x2A48, page_offset_i=0xA4C -> page_offset_match_o=1 (bits [11:3] match). page_offset_i=0xA50 -> page_offset_match_o=0.
